// File: rtl/csr_timer_if.sv
// CSR access bus between the core and csr_timer: instruction fields in, config read data out.
interface csr_timer_if;
   localparam int unsigned AddrW = 12;
   localparam int unsigned OpW   = 3;
   localparam int unsigned ZimmW = 5;
   localparam int unsigned DataW = 32;

   logic             csr_enable;
   logic [AddrW-1:0] csr_addr;
   logic [OpW-1:0]   csr_op;
   logic [ZimmW-1:0] rs1_zimm;
   logic [DataW-1:0] rs1_data;
   logic [DataW-1:0] direct_out;

   modport master (
      output csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data,
      input  direct_out
   );

   modport slave (
      input  csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data,
      output direct_out
   );
endinterface

// File: rtl/csr_timer.sv
// CSR-programmed periodic timer: config = {counter_top, prescaler}, pulse every counter_top << prescaler cycles.
// Optional one-shot mode (config bit 20) enabled by defining CSR_TIMER_ONESHOT_EN.
module csr_timer #(
   parameter logic [11:0] CsrAddr = 12'h400
) (
   input  logic        clk,
   input  logic        reset,
   csr_timer_if.slave  bus,
   output logic        interrupt
);

   localparam int unsigned DataW  = 32;
   localparam int unsigned TopW   = 16;
   localparam int unsigned PreW   = 4;
   localparam int unsigned TopLsb = 4;
   localparam int unsigned TopMsb = TopLsb + TopW - 1;
`ifdef CSR_TIMER_ONESHOT_EN
   localparam int unsigned CfgW   = 21;
`else
   localparam int unsigned CfgW   = 20;
`endif

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CfgW-1:0]  r_cfg;
   logic [CfgW-1:0]  w_cfg_nxt;
   logic [CfgW-1:0]  w_cfg_wr;
   logic [DataW-1:0] r_cnt;
   logic [DataW-1:0] w_cnt_nxt;
   logic             r_irq;
   logic             w_irq_nxt;

   logic [DataW-1:0] w_operand;
   logic [DataW-1:0] w_result;
   logic             w_op_valid;
   logic             w_wr;
   logic [TopW-1:0]  w_top;
   logic [PreW-1:0]  w_pre;
   logic [DataW-1:0] w_compare;
   logic [DataW-1:0] w_cmp_last;
   logic             w_expire;
   logic             w_oneshot;

   // Read port always shows the stored value, so the pre-write value is seen during an access.
   assign bus.direct_out = DataW'(r_cfg);
   assign interrupt      = r_irq;

   assign w_top      = r_cfg[TopMsb:TopLsb];
   assign w_pre      = r_cfg[PreW-1:0];
   assign w_compare  = DataW'(w_top) << w_pre;
   assign w_cmp_last = w_compare - DataW'(1);

`ifdef CSR_TIMER_ONESHOT_EN
   assign w_oneshot = r_cfg[CfgW-1];
`else
   assign w_oneshot = 1'b0;
`endif

   // Operand select and read-modify-write; funct3[2] picks the zero-extended immediate.
   assign w_operand = bus.csr_op[2] ? DataW'(bus.rs1_zimm) : bus.rs1_data;

   always_comb begin
      w_op_valid = 1'b1;
      w_result   = w_operand;
      case (bus.csr_op[1:0])
         2'b01:   w_result = w_operand;
         2'b10:   w_result = DataW'(r_cfg) | w_operand;
         2'b11:   w_result = DataW'(r_cfg) & ~w_operand;
         default: w_op_valid = 1'b0;
      endcase
   end

   assign w_cfg_wr = CfgW'(w_result);
   assign w_wr     = bus.csr_enable && (bus.csr_addr == CsrAddr) && w_op_valid;
   assign w_expire = (r_state == S_RUN) && (r_cnt == w_cmp_last);

   // Next-state logic: a write always wins over an expiry in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cfg_nxt   = r_cfg;
      w_cnt_nxt   = r_cnt;
      w_irq_nxt   = 1'b0;
      if (w_wr) begin
         w_cfg_nxt   = w_cfg_wr;
         w_cnt_nxt   = '0;
         w_state_nxt = (w_cfg_wr[TopMsb:TopLsb] != '0) ? S_RUN : S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_cnt_nxt = '0;
            end
            S_RUN: begin
               if (w_expire) begin
                  w_cnt_nxt = '0;
                  w_irq_nxt = 1'b1;
                  if (w_oneshot) begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + DataW'(1);
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cfg <= '0;
         r_cnt <= '0;
         r_irq <= 1'b0;
      end else begin
         r_cfg <= w_cfg_nxt;
         r_cnt <= w_cnt_nxt;
         r_irq <= w_irq_nxt;
      end
   end

endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: a time-since-last-write model checked every cycle, plus directed literal checks.
module tb_csr_timer;

`ifdef CSR_TIMER_ONESHOT_EN
   localparam longint CFG_MASK = 64'h1F_FFFF;
   localparam bit     ONESHOT  = 1'b1;
`else
   localparam longint CFG_MASK = 64'h0F_FFFF;
   localparam bit     ONESHOT  = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic interrupt;

   csr_timer_if bus ();

   csr_timer #(.CsrAddr(12'h400)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .interrupt (interrupt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: config value, edge index of the last write/reset, and the period it set up.
   longint m_cfg   = 0;
   longint m_wedge = 0;
   longint m_cmp   = 0;
   bit     m_run   = 1'b0;
   bit     m_os    = 1'b0;
   bit     m_valid = 1'b0;
   longint edge_n  = 0;

   function automatic bit op_ok(input logic [2:0] op);
      return (op == 3'd1) || (op == 3'd2) || (op == 3'd3) ||
             (op == 3'd5) || (op == 3'd6) || (op == 3'd7);
   endfunction

   function automatic longint new_val(input logic [2:0] op, input logic [31:0] data,
                                      input logic [4:0] zimm, input longint old);
      longint opnd;
      longint r;
      opnd = op[2] ? longint'(zimm) : longint'(data);
      case (op[1:0])
         2'b01:   r = opnd;
         2'b10:   r = old | opnd;
         default: r = old & ~opnd;
      endcase
      return r & CFG_MASK;
   endfunction

   // Interrupt is high after edge n iff n is a positive multiple of the period since the last write.
   function automatic bit exp_irq();
      longint d;
      d = edge_n - m_wedge;
      if (!m_run || m_cmp == 0 || d <= 0) return 1'b0;
      if ((d % m_cmp) != 0) return 1'b0;
      if (m_os && d != m_cmp) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      edge_n = edge_n + 1;
      if (!reset) begin
         m_cfg   = 0;
         m_run   = 1'b0;
         m_os    = 1'b0;
         m_cmp   = 0;
         m_wedge = edge_n;
         m_valid = 1'b1;
      end else if (bus.csr_enable && bus.csr_addr == 12'h400 && op_ok(bus.csr_op)) begin
         m_cfg   = new_val(bus.csr_op, bus.rs1_data, bus.rs1_zimm, m_cfg);
         m_cmp   = ((m_cfg >> 4) & 64'hFFFF) << (m_cfg & 64'hF);
         m_run   = (((m_cfg >> 4) & 64'hFFFF) != 0);
         m_os    = ONESHOT && m_cfg[20];
         m_wedge = edge_n;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("direct_out", bus.direct_out, m_cfg);
         chk("interrupt", interrupt, exp_irq());
      end
   end

   longint w_edge = 0;

   // One-cycle CSR access; checks the pre-write read value during the access cycle.
   task automatic csr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] data,
                      input logic [4:0] zimm, input logic [31:0] exp_pre, input string nm);
      bus.csr_enable = 1'b1;
      bus.csr_op     = op;
      bus.csr_addr   = addr;
      bus.rs1_data   = data;
      bus.rs1_zimm   = zimm;
      #1;
      chk({nm, "_pre"}, bus.direct_out, exp_pre);
      @(posedge clk);
      #1;
      bus.csr_enable = 1'b0;
      w_edge = edge_n;
   endtask

   // Hand-stated pulse pattern relative to the last csr() call: pulse every 'period' edges.
   task automatic run_chk(input int n, input int period, input bit os, input string nm);
      longint k;
      bit     e;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         k = edge_n - w_edge;
         e = (period != 0) && ((k % period) == 0) && (!os || k == period);
         chk(nm, interrupt, e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      reset          = 1'b0;
      bus.csr_enable = 1'b0;
      bus.csr_addr   = '0;
      bus.csr_op     = '0;
      bus.rs1_zimm   = '0;
      bus.rs1_data   = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      chk("reset_direct_out", bus.direct_out, 32'h0);
      chk("reset_interrupt", interrupt, 1'b0);

      // top=3 pre=1: period 6, first pulse 6 edges after the write.
      csr(3'd1, 12'h400, 32'h0003_1, 5'd0, 32'h0, "rw31");
      chk("model_cmp6", m_cmp, 64'd6);
      chk("rw31_readback", bus.direct_out, 32'h31);
      run_chk(13, 6, 1'b0, "rw31_pulse");

      // Clear-bits write mid-count: value becomes 'h01, top=0 -> idle, no pulse.
      csr(3'd1, 12'h400, 32'h31, 5'd0, 32'h31, "rw31b");
      run_chk(2, 6, 1'b0, "rw31b_pulse");
      csr(3'd3, 12'h400, 32'hF0, 5'd0, 32'h31, "rc_f0");
      chk("rc_f0_readback", bus.direct_out, 32'h01);
      run_chk(10, 0, 1'b0, "rc_nopulse");

      // Period 4; rewrite exactly on the last count suppresses that pulse.
      csr(3'd1, 12'h400, 32'h21, 5'd0, 32'h01, "rw21");
      run_chk(3, 4, 1'b0, "rw21_pulse");
      csr(3'd1, 12'h400, 32'h21, 5'd0, 32'h21, "rw21_last");
      chk("wr_at_last_nopulse", interrupt, 1'b0);
      run_chk(6, 4, 1'b0, "rw21_restart");
      csr(3'd2, 12'h400, 32'h0, 5'd0, 32'h21, "rs_zero");
      chk("rs_zero_readback", bus.direct_out, 32'h21);
      run_chk(8, 4, 1'b0, "rs_zero_pulse");

      // Other address and illegal funct3 are ignored; counting phase continues.
      csr(3'd5, 12'h401, 32'h0, 5'd5, 32'h21, "rwi_401");
      csr(3'd0, 12'h400, 32'hFFFFF, 5'd31, 32'h21, "op0");
      csr(3'd4, 12'h400, 32'hFFFFF, 5'd31, 32'h21, "op4");
      chk("ignored_readback", bus.direct_out, 32'h21);
      idle(5);

      // Immediate set/clear round trip.
      csr(3'd6, 12'h400, 32'h0, 5'h1F, 32'h21, "rsi_1f");
      csr(3'd7, 12'h400, 32'h0, 5'h1E, 32'h3F, "rci_1e");
      chk("rsci_readback", bus.direct_out, 32'h21);
      run_chk(8, 4, 1'b0, "rci_pulse");

      // Upper operand bits beyond the register width are discarded.
      csr(3'd1, 12'h400, 32'hFFF0_0031, 5'd0, 32'h21, "rw_hi");
`ifdef CSR_TIMER_ONESHOT_EN
      chk("rw_hi_readback", bus.direct_out, 32'h10_0031);
      run_chk(14, 6, 1'b1, "rw_hi_pulse");
      csr(3'd1, 12'h400, 32'h10, 5'd0, 32'h10_0031, "rw10");
`else
      chk("rw_hi_readback", bus.direct_out, 32'h31);
      run_chk(14, 6, 1'b0, "rw_hi_pulse");
      csr(3'd1, 12'h400, 32'h10, 5'd0, 32'h31, "rw10");
`endif

      // Period 1 pulses every edge; reset (with a concurrent write) aborts it.
      run_chk(3, 1, 1'b0, "rw10_pulse");
      reset          = 1'b0;
      bus.csr_enable = 1'b1;
      bus.csr_op     = 3'd1;
      bus.csr_addr   = 12'h400;
      bus.rs1_data   = 32'h55;
      @(posedge clk);
      #1;
      chk("rst_mid_interrupt", interrupt, 1'b0);
      chk("rst_mid_direct_out", bus.direct_out, 32'h0);
      reset          = 1'b1;
      bus.csr_enable = 1'b0;
      idle(3);
      chk("post_rst_interrupt", interrupt, 1'b0);
      chk("post_rst_direct_out", bus.direct_out, 32'h0);

      // One-shot bit: single pulse when enabled, periodic and truncated otherwise.
      csr(3'd1, 12'h400, 32'h10_0020, 5'd0, 32'h0, "rw_os");
`ifdef CSR_TIMER_ONESHOT_EN
      chk("rw_os_readback", bus.direct_out, 32'h10_0020);
`else
      chk("rw_os_readback", bus.direct_out, 32'h20);
`endif
      run_chk(8, 2, ONESHOT, "rw_os_pulse");

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
